// File: rtl/pipelined_cond_controller.sv
// pipelined_cond_controller
// Control unit for the 4-stage (D/E/M/W) ARM-subset datapath. Decode is
// combinational in D; control is registered into E, M and W. Condition
// codes are evaluated in E against the architectural flag register, and a
// failed condition suppresses every write the instruction would make.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   Op, Funct, Rd     instruction fields in D
//   Cond              condition field in D
//   ALUFlags          {N,Z,C,V} produced by the ALU for the instruction in E
//   FlushE            inserts a bubble into E at the next edge
//   RegSrcD, ImmSrcD  register-read and immediate-extend selects (D)
//   LinkD, UndefD     BL write-to-R14 and undefined-opcode indications (D)
//   ALUControlE, ALUSrcE, MemToRegE, BranchTakenE, CondExE   E-stage control
//   FlagsQ            architectural {N,Z,C,V}
//   RegWriteM, MemWriteM, MemToRegM                          M-stage control
//   RegWriteW, MemToRegW, PCSrcW                             W-stage control

module pipelined_cond_controller #(
    parameter int ALUCTRL_W    = 4,
    parameter bit EARLY_BRANCH = 1'b1,
    parameter bit LINK_ENABLE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           Cond,
    input  logic [3:0]           ALUFlags,
    input  logic                 FlushE,
    output logic [1:0]           RegSrcD,
    output logic [1:0]           ImmSrcD,
    output logic                 LinkD,
    output logic                 UndefD,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 MemToRegE,
    output logic                 BranchTakenE,
    output logic                 CondExE,
    output logic [3:0]           FlagsQ,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 MemToRegM,
    output logic                 RegWriteW,
    output logic                 MemToRegW,
    output logic                 PCSrcW
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_EOR = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0100;

    // ---------------- D: decode ----------------
    logic [3:0] cmd;
    logic       isTest;
    logic       isArith;
    logic       nzWrite;

    logic       regWriteD;
    logic       memWriteD;
    logic       memToRegD;
    logic       branchD;
    logic       aluSrcD;
    logic [3:0] aluCtrlD;
    logic [1:0] flagWriteD;
    logic       pcsD;

    assign cmd     = Funct[4:1];
    // TST/TEQ/CMP/CMN: flags only, no register result
    assign isTest  = (cmd[3:2] == 2'b10);
    assign isArith = ((cmd >= 4'd2) && (cmd <= 4'd7)) || (cmd == 4'd10) || (cmd == 4'd11);
    assign nzWrite = Funct[0] | isTest;

    always_comb begin
        regWriteD  = 1'b0;
        memWriteD  = 1'b0;
        memToRegD  = 1'b0;
        branchD    = 1'b0;
        aluSrcD    = 1'b0;
        aluCtrlD   = ALU_AND;
        flagWriteD = 2'b00;
        RegSrcD    = 2'b00;
        ImmSrcD    = 2'b00;
        LinkD      = 1'b0;
        UndefD     = 1'b0;
        case (Op)
            2'b00: begin
                aluSrcD    = Funct[5];
                regWriteD  = ~isTest;
                flagWriteD = {nzWrite, nzWrite & isArith};
                case (cmd)
                    4'b1000: aluCtrlD = ALU_AND;
                    4'b1001: aluCtrlD = ALU_EOR;
                    4'b1010: aluCtrlD = ALU_SUB;
                    4'b1011: aluCtrlD = ALU_ADD;
                    default: aluCtrlD = cmd;
                endcase
            end
            2'b01: begin
                regWriteD = Funct[0];
                memWriteD = ~Funct[0];
                memToRegD = Funct[0];
                aluSrcD   = ~Funct[5];
                aluCtrlD  = Funct[3] ? ALU_ADD : ALU_SUB;
                ImmSrcD   = 2'b01;
                RegSrcD   = 2'b10;
            end
            2'b10: begin
                branchD   = 1'b1;
                aluSrcD   = 1'b1;
                aluCtrlD  = ALU_ADD;
                ImmSrcD   = 2'b10;
                RegSrcD   = 2'b01;
                LinkD     = LINK_ENABLE & Funct[4];
                regWriteD = LINK_ENABLE & Funct[4];
            end
            default: begin
                UndefD = 1'b1;
            end
        endcase
    end

    // A BL writes R14, never the PC, even if Rd happens to decode as 15.
    // With late resolution every branch redirects through the W-stage PC write.
    assign pcsD = (regWriteD & (Rd == 4'd15) & ~LinkD) | (branchD & ~EARLY_BRANCH);

    // ---------------- E: registered control ----------------
    logic       regWriteE;
    logic       memWriteE;
    logic       branchE;
    logic [1:0] flagWriteE;
    logic       pcsE;
    logic [3:0] condE;

    always_ff @(posedge clk) begin
        if (reset) begin
            regWriteE   <= 1'b0;
            memWriteE   <= 1'b0;
            MemToRegE   <= 1'b0;
            branchE     <= 1'b0;
            flagWriteE  <= 2'b00;
            pcsE        <= 1'b0;
            ALUControlE <= '0;
            ALUSrcE     <= 1'b0;
            condE       <= 4'b0000;
        end else begin
            if (FlushE) begin
                regWriteE  <= 1'b0;
                memWriteE  <= 1'b0;
                MemToRegE  <= 1'b0;
                branchE    <= 1'b0;
                flagWriteE <= 2'b00;
                pcsE       <= 1'b0;
            end else begin
                regWriteE  <= regWriteD;
                memWriteE  <= memWriteD;
                MemToRegE  <= memToRegD;
                branchE    <= branchD;
                flagWriteE <= flagWriteD;
                pcsE       <= pcsD;
            end
            // Datapath selects of a bubble are harmless: its writes are all zero.
            ALUControlE <= ALUCTRL_W'(aluCtrlD);
            ALUSrcE     <= aluSrcD;
            condE       <= Cond;
        end
    end

    // Condition check against the architectural flags
    logic flagN, flagZ, flagC, flagV;
    assign {flagN, flagZ, flagC, flagV} = FlagsQ;

    always_comb begin
        CondExE = 1'b0;
        case (condE)
            4'b0000: CondExE = flagZ;
            4'b0001: CondExE = ~flagZ;
            4'b0010: CondExE = flagC;
            4'b0011: CondExE = ~flagC;
            4'b0100: CondExE = flagN;
            4'b0101: CondExE = ~flagN;
            4'b0110: CondExE = flagV;
            4'b0111: CondExE = ~flagV;
            4'b1000: CondExE = flagC & ~flagZ;
            4'b1001: CondExE = ~flagC | flagZ;
            4'b1010: CondExE = (flagN == flagV);
            4'b1011: CondExE = (flagN != flagV);
            4'b1100: CondExE = ~flagZ & (flagN == flagV);
            4'b1101: CondExE = flagZ | (flagN != flagV);
            4'b1110: CondExE = 1'b1;
            default: CondExE = 1'b0;
        endcase
    end

    assign BranchTakenE = branchE & CondExE & EARLY_BRANCH;

    // Flags update at the edge ending E, so the following instruction sees
    // them directly in its own E cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            FlagsQ <= 4'b0000;
        end else begin
            if (flagWriteE[1] & CondExE) FlagsQ[3:2] <= ALUFlags[3:2];
            if (flagWriteE[0] & CondExE) FlagsQ[1:0] <= ALUFlags[1:0];
        end
    end

    // ---------------- M and W ----------------
    logic pcSrcM;

    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            MemToRegM <= 1'b0;
            pcSrcM    <= 1'b0;
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
            PCSrcW    <= 1'b0;
        end else begin
            RegWriteM <= regWriteE & CondExE;
            MemWriteM <= memWriteE & CondExE;
            MemToRegM <= MemToRegE;
            pcSrcM    <= pcsE & CondExE;
            RegWriteW <= RegWriteM;
            MemToRegW <= MemToRegM;
            PCSrcW    <= pcSrcM;
        end
    end

endmodule

// File: doc/pipelined_cond_controller.md
Name: pipelined_cond_controller

Overview:
- Parametrised successor to the current pipelined controller for the 4-stage (D/E/M/W) ARM-subset datapath.
- Combinational decode in D; registered control in E, M and W.
- Adds the following over the current controller:
  - full 16-command data-processing decode with split NZ/CV flag writes;
  - S-bit-controlled flag register;
  - conditional execution evaluated in E on the architectural flags;
  - FlushE hazard input;
  - optional branch-with-link;
  - selectable branch-resolution stage.

Parameters:
ALUCTRL_W, 4, width of ALUControl; command codes occupy the low 4 bits, upper bits are zero.
EARLY_BRANCH, 1, 1: branches resolve in E via BranchTakenE; 0: branches redirect via PCSrcW and BranchTakenE is tied 0.
LINK_ENABLE, 1, 1: branch with Funct[4]=1 writes R14 (BL); 0: all branches have RegWrite=0.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
Op  in  2  instr[27:26]
Funct  in  6  instr[25:20]
Rd  in  4  instr[15:12]
Cond  in  4  instr[31:28]
ALUFlags  in  4  {N,Z,C,V} from ALU in E
FlushE  in  1  bubble into E at next edge
RegSrcD  out  2  register-read source selects
ImmSrcD  out  2  00 DP imm8, 01 mem imm12, 10 branch imm24
LinkD  out  1  write address is R14 (BL)
UndefD  out  1  Op==11 decoded
ALUControlE  out  ALUCTRL_W  ALU operation
ALUSrcE  out  1  1 = immediate operand B
MemToRegE  out  1  load in E (for load-use stall detection)
BranchTakenE  out  1  taken branch in E
CondExE  out  1  condition passed for instruction in E
FlagsQ  out  4  architectural {N,Z,C,V}
RegWriteM  out  1  gated register write in M
MemWriteM  out  1  gated memory write in M
MemToRegM  out  1  load in M
RegWriteW  out  1  gated register write in W
MemToRegW  out  1  result select in W
PCSrcW  out  1  PC write from W

Behaviour:
- Latency:
  - decode outputs are combinational from Op/Funct/Rd;
  - each E register captures D at the rising edge; M captures E, W captures M.
- Reset: every E/M/W register is 0 and FlagsQ=0000 at the first edge with reset=1.
  - A reset in the middle of an instruction sequence discards all in-flight instructions; no gated write is asserted on the following cycle.
- Data-processing decode (Op=00): cmd=Funct[4:1], S=Funct[0], ALUSrc=Funct[5], ImmSrc=00, RegSrc=00.
  - ALUControl = cmd, except TST(1000)->AND(0000), TEQ(1001)->EOR(0001), CMP(1010)->SUB(0010), CMN(1011)->ADD(0100).
  - RegWrite = 1 unless cmd[3:2]==10.
  - FlagWrite[1] (NZ) = S, or 1 when cmd[3:2]==10.
  - FlagWrite[0] (CV) = FlagWrite[1] AND cmd is arithmetic: 0010..0111, 1010, 1011.
- Memory decode (Op=01): L=Funct[0], U=Funct[3].
  - RegWrite=L, MemWrite=~L, MemToReg=L, ALUSrc=~Funct[5].
  - ALUControl = U ? ADD : SUB.
  - ImmSrc=01, RegSrc=10, FlagWrite=00.
- Branch decode (Op=10):
  - Branch=1, ALUSrc=1, ALUControl=ADD, ImmSrc=10, RegSrc=01.
  - LinkD = RegWrite = LINK_ENABLE & Funct[4].
- Undefined (Op=11): UndefD=1; RegWrite, MemWrite, Branch and FlagWrite are all 0.
- PCS (decode) = (RegWrite & Rd==15 & ~LinkD) | (Branch & ~EARLY_BRANCH).
- CondExE evaluates CondE against FlagsQ:
  - standard ARM encodings 0000..1110 (EQ..AL);
  - 1111 gives 0.
- Gating in E (CondExE gates all writes):
  - BranchTakenE = BranchE & CondExE & EARLY_BRANCH.
  - RegWriteM <= RegWriteE & CondExE; MemWriteM <= MemWriteE & CondExE; PCSrcM <= PCSE & CondExE.
- Flag update: at the edge ending E:
  - NZ <= ALUFlags[3:2] if FlagWriteE[1] & CondExE;
  - CV <= ALUFlags[1:0] if FlagWriteE[0] & CondExE;
  - otherwise the flags hold.
  - The next instruction in E sees the updated flags, so no flag forwarding is needed.
- FlushE=1: RegWriteE, MemWriteE, MemToRegE, BranchE, FlagWriteE and PCSE load 0 at the edge; other E fields are don't-care.
  - Flush wins over a valid D.
  - M/W advance normally.
  - reset dominates FlushE.
- M->W: RegWriteW, MemToRegW and PCSrcW are copied from M.

Test Plan:
- ADDS (Funct=001001, Cond=1110) with ALUFlags=0110 -> CondExE=1, FlagsQ=0110 one edge later, RegWriteM=1 at the next cycle, RegWriteW=1 the cycle after.
- CMP (Funct=010101) then BEQ (Op=10, Cond=0000) with ALUFlags Z=1 -> ALUControlE=0010 and RegWriteM=0 for CMP; BranchTakenE=1 for BEQ. The same sequence with Z=0 -> BranchTakenE=0.
- ANDS after a flag state of C=1,V=1 with ALUFlags=1000 -> FlagsQ=1011 (CV preserved).
- Condition fails: STR with Cond=0001 while Z=1 -> MemWriteM=0. The same STR with FlushE=1 in D -> MemToRegE=0 and MemWriteM=0.
- Branch-with-link and resolution-stage modes:
  - BL (Funct[4]=1) with LINK_ENABLE=1 -> LinkD=1 and RegWriteW=1 three edges later;
  - with LINK_ENABLE=0 -> RegWriteW=0;
  - with EARLY_BRANCH=0 -> B gives BranchTakenE=0 and PCSrcW=1.
- Reset and undefined opcodes:
  - assert reset with a MOV to R15 in M -> PCSrcW=0, FlagsQ=0000;
  - Op=11 -> UndefD=1 and no write ever reaches W.
